// File: rtl/maxpool_2b2.sv
// 2x2 stride-2 max-pooling stage: raster-order feature-map pixels in, pooled pixels out.
// Optional build macro MAXPOOL_RELU_EN fuses a ReLU onto the pooled output.
module maxpool_2b2 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MAP_W  = 4,
    parameter int unsigned MAP_H  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PW     = MAP_W / 2;
    localparam int unsigned PH     = MAP_H / 2;
    localparam int unsigned PCOL_W = (PW > 1) ? $clog2(PW) : 1;
    localparam int unsigned PROW_W = (PH > 1) ? $clog2(PH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;

    // Pixel position is kept as (pair index, odd/even phase) for column and row.
    logic              odd_col;
    logic              odd_row;
    logic [PCOL_W-1:0] pcol;
    logic [PROW_W-1:0] prow;

    logic signed [DATA_W-1:0] h;
    logic signed [DATA_W-1:0] rowbuf [PW];

    logic signed [DATA_W-1:0] pair_max_c;
    logic signed [DATA_W-1:0] pool_max_c;
    logic signed [DATA_W-1:0] pool_out_c;
    logic                     accept_c;
    logic                     last_pix_c;

    always_comb begin
        pair_max_c = ($signed(in_data) > h) ? $signed(in_data) : h;
        pool_max_c = (rowbuf[pcol] > pair_max_c) ? rowbuf[pcol] : pair_max_c;
`ifdef MAXPOOL_RELU_EN
        pool_out_c = pool_max_c[DATA_W-1] ? '0 : pool_max_c;
`else
        pool_out_c = pool_max_c;
`endif
        accept_c   = in_ready && in_valid;
        last_pix_c = odd_col && odd_row
                     && (pcol == PCOL_W'(PW - 1))
                     && (prow == PROW_W'(PH - 1));
    end

    // Row buffer needs no reset: each entry is written on an even row before use.
    always_ff @(posedge clk) begin
        if (accept_c && odd_col && !odd_row) begin
            rowbuf[pcol] <= pair_max_c;
        end
    end

    // Control FSM, position counters, hold register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            odd_col   <= 1'b0;
            odd_row   <= 1'b0;
            pcol      <= '0;
            prow      <= '0;
            h         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        odd_col  <= 1'b0;
                        odd_row  <= 1'b0;
                        pcol     <= '0;
                        prow     <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        if (!odd_col) begin
                            h <= $signed(in_data);
                        end else if (odd_row) begin
                            out_data  <= pool_out_c;
                            out_valid <= 1'b1;
                            out_last  <= last_pix_c;
                        end
                        odd_col <= !odd_col;
                        if (odd_col) begin
                            if (pcol == PCOL_W'(PW - 1)) begin
                                pcol    <= '0;
                                odd_row <= !odd_row;
                                if (odd_row) begin
                                    prow <= prow + PROW_W'(1);
                                end
                            end else begin
                                pcol <= pcol + PCOL_W'(1);
                            end
                        end
                        if (last_pix_c) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_2b2.sv
// Self-checking bench for maxpool_2b2 (4x4 map, 8-bit pixels); honours MAXPOOL_RELU_EN.
module tb_maxpool_2b2;

    localparam int DATA_W = 8;
    localparam int MAP_W  = 4;
    localparam int MAP_H  = 4;
    localparam int NPIX   = MAP_W * MAP_H;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    maxpool_2b2 #(.DATA_W(DATA_W), .MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference model: frame-level pooling over the accepted pixel sequence.
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t m_state = M_IDLE;
    int  pix [NPIX];
    int  k      = 0;
    bit  pend_v = 0;
    bit  pend_l = 0;
    int  m_out  = 0;
    int  got[$];

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'($signed(out_data)), 0);
            chk("rst_out_last", int'(out_last), 0);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            m_state = M_IDLE;
            pend_v  = 0;
            pend_l  = 0;
            m_out   = 0;
            k       = 0;
        end else begin
            chk("out_valid", int'(out_valid), int'(pend_v));
            chk("out_last", int'(out_last), int'(pend_l));
            chk("out_data", int'($signed(out_data)), m_out);
            chk("in_ready", int'(in_ready), int'(m_state == M_RUN));
            chk("busy", int'(busy), int'(m_state == M_RUN));
            chk("done", int'(done), int'(m_state == M_DONE));
            if (out_valid) got.push_back(int'($signed(out_data)));
            pend_v = 0;
            pend_l = 0;
            case (m_state)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_state = M_RUN;
                        k = 0;
                    end
                end
                M_RUN: begin
                    if (in_valid) begin
                        int r, c, e;
                        pix[k] = int'($signed(in_data));
                        r = k / MAP_W;
                        c = k % MAP_W;
                        if ((r % 2 == 1) && (c % 2 == 1)) begin
                            e = max2(max2(pix[(r-1)*MAP_W + c-1], pix[(r-1)*MAP_W + c]),
                                     max2(pix[r*MAP_W + c-1], pix[r*MAP_W + c]));
                            m_out  = relu(e);
                            pend_v = 1;
                            pend_l = (k == NPIX - 1);
                        end
                        if (k == NPIX - 1) m_state = M_DONE;
                        k++;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    int cur [NPIX];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_valid);
        start    = 1'b1;
        in_valid = with_valid;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic drive(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(cur[i]);
            tick();
            if (bubbles) begin
                in_valid = 1'b0;
                in_data  = DATA_W'(8'h55);
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_got(input string name, input int e0, input int e1,
                             input int e2, input int e3);
        int exp [4];
        exp = '{e0, e1, e2, e3};
        chk({name, "_count"}, got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk({name, "_val"}, got[i], relu(exp[i]));
        end
        got.delete();
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NPIX; i++) cur[i] = v;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic frame, continuous valid
        cur = '{1, 5, 2, 3, 4, 0, 9, -1, -3, -7, 6, 6, -2, -8, 6, 8};
        got.delete();
        do_start(1'b0);
        drive(NPIX, 1'b0);
        repeat (3) tick();
        check_got("basic", 5, 9, -2, 8);
        chk("basic_done", int'(done), 1);
        chk("basic_in_ready", int'(in_ready), 0);

        // Same frame with a bubble after every pixel, restarted from DONE
        do_start(1'b0);
        drive(NPIX, 1'b1);
        repeat (3) tick();
        check_got("bubbles", 5, 9, -2, 8);

        // Valid pixels before start are ignored; start+valid consumes nothing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(99);
        repeat (3) tick();
        chk("idle_in_ready", int'(in_ready), 0);
        chk("idle_busy", int'(busy), 0);
        in_data = DATA_W'(100);
        do_start(1'b1);
        drive(NPIX, 1'b0);
        repeat (3) tick();
        check_got("prestart", 5, 9, -2, 8);

        // Asynchronous reset mid-frame, then a frame of -128
        do_start(1'b0);
        drive(9, 1'b0);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        chk("async_rst_out_data", int'($signed(out_data)), 0);
        tick();
        rst = 1'b0;
        tick();
        got.delete();
        fill(-128);
        do_start(1'b0);
        drive(NPIX, 1'b0);
        repeat (3) tick();
        check_got("after_rst", -128, -128, -128, -128);

        // Back-to-back frame started from DONE
        fill(7);
        chk("b2b_pre_done", int'(done), 1);
        do_start(1'b0);
        chk("b2b_done_fall", int'(done), 0);
        chk("b2b_busy_rise", int'(busy), 1);
        drive(NPIX, 1'b0);
        repeat (3) tick();
        check_got("b2b", 7, 7, 7, 7);
        chk("b2b_done", int'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
